// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the data-memory responder
package mem_pkg;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   localparam logic EXT_S = 1'b0;
   localparam logic EXT_U = 1'b1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_st_t;
endpackage

// File: rtl/mem_lane.sv
// rtl/mem_lane.sv - byte-lane steering: store enables/replication, load extraction/extension
module mem_lane
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        ext,
   input  logic [31:0] w_data,
   input  logic [31:0] rd_word,
   output logic [3:0]  be,
   output logic [31:0] wr_word,
   output logic [31:0] ld_data
);
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      be      = 4'b0000;
      wr_word = w_data;
      ld_data = rd_word;
      case (off)
         2'd0:    b = rd_word[7:0];
         2'd1:    b = rd_word[15:8];
         2'd2:    b = rd_word[23:16];
         default: b = rd_word[31:24];
      endcase
      h = off[1] ? rd_word[31:16] : rd_word[15:0];
      case (size)
         SZ_B: begin
            be      = 4'b0001 << off;
            wr_word = {4{w_data[7:0]}};
            ld_data = (ext == EXT_U) ? {24'd0, b} : {{24{b[7]}}, b};
         end
         SZ_H: begin
            be      = off[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{w_data[15:0]}};
            ld_data = (ext == EXT_U) ? {16'd0, h} : {{16{h[15]}}, h};
         end
         SZ_W: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store responder with wait states, fault checks and word array
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Mem_read,
   input  logic        Mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] w_data,
   input  logic [1:0]  Size_s,
   input  logic        SE_s,
   output logic [31:0] r_data,
   output logic        ready,
   output logic        fault,
   output logic        busy
);
   localparam int         DEPTH    = 1 << (ADDR_W - 2);
   localparam logic [3:0] CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

   mem_st_t     state, nxt;
   logic [3:0]  cnt;
   logic [31:0] a_q, wd_q;
   logic [1:0]  sz_q;
   logic        se_q, rd_q, wr_q, fault_q;
   logic        commit;

   logic [31:0] s_addr, s_wd;
   logic [1:0]  s_sz;
   logic        s_se, s_rd, s_wr, s_fault;
   logic [ADDR_W-3:0] idx;
   logic [31:0] rd_word, wr_word, ld_data;
   logic [3:0]  be;

   logic [31:0] mem [DEPTH];

   // With WAIT=0 the commit edge is also the accept edge, so use live inputs in IDLE.
   always_comb begin
      s_addr = a_q;
      s_wd   = wd_q;
      s_sz   = sz_q;
      s_se   = se_q;
      s_rd   = rd_q;
      s_wr   = wr_q;
      if (state == IDLE) begin
         s_addr = addr;
         s_wd   = w_data;
         s_sz   = Size_s;
         s_se   = SE_s;
         s_rd   = Mem_read;
         s_wr   = Mem_write;
      end
      s_fault = (s_rd & s_wr) | (s_sz == SZ_X) |
                ((s_sz == SZ_H) & s_addr[0]) |
                ((s_sz == SZ_W) & (s_addr[1:0] != 2'b00)) |
                ((s_addr >> ADDR_W) != 32'd0);
   end

   assign idx     = s_addr[ADDR_W-1:2];
   assign rd_word = mem[idx];

   mem_lane u_lane (
      .size    (s_sz),
      .off     (s_addr[1:0]),
      .ext     (s_se),
      .w_data  (s_wd),
      .rd_word (rd_word),
      .be      (be),
      .wr_word (wr_word),
      .ld_data (ld_data)
   );

   always_comb begin
      nxt    = state;
      commit = 1'b0;
      case (state)
         IDLE: if (Mem_read | Mem_write) begin
            nxt    = (WAIT == 0) ? RESP : BUSY;
            commit = (WAIT == 0);
         end
         BUSY: if (cnt == 4'd0) begin
            nxt    = RESP;
            commit = 1'b1;
         end
         RESP: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         r_data  <= 32'd0;
         fault_q <= 1'b0;
         a_q     <= 32'd0;
         wd_q    <= 32'd0;
         sz_q    <= SZ_B;
         se_q    <= EXT_S;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && (Mem_read | Mem_write)) begin
            a_q  <= addr;
            wd_q <= w_data;
            sz_q <= Size_s;
            se_q <= SE_s;
            rd_q <= Mem_read;
            wr_q <= Mem_write;
            cnt  <= CNT_INIT;
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) begin
            fault_q <= s_fault;
            if (s_rd && !s_fault)
               r_data <= ld_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && commit && s_wr && !s_fault) begin
         for (int i = 0; i < 4; i++)
            if (be[i])
               mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
   end

   assign ready = (state == RESP);
   assign fault = ready & fault_q;
   assign busy  = (state != IDLE);
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized and directed checks of three responders (WAIT 1, 3, 0)
module tb_data_mem_ctrl;
   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic        mr [3];
   logic        mw [3];
   logic        se [3];
   logic [31:0] ad [3];
   logic [31:0] wd [3];
   logic [1:0]  sz [3];
   logic [31:0] rdat [3];
   logic        rdy [3];
   logic        flt [3];
   logic        bsy [3];

   always #5 clk = ~clk;

   function automatic int wt(int g);
      return (g == 0) ? 1 : ((g == 1) ? 3 : 0);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      data_mem_ctrl #(.ADDR_W(10), .WAIT((g == 0) ? 1 : ((g == 1) ? 3 : 0))) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .Mem_read  (mr[g]),
         .Mem_write (mw[g]),
         .addr      (ad[g]),
         .w_data    (wd[g]),
         .Size_s    (sz[g]),
         .SE_s      (se[g]),
         .r_data    (rdat[g]),
         .ready     (rdy[g]),
         .fault     (flt[g]),
         .busy      (bsy[g])
      );
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference: per-instance byte memory plus the cycle numbers each response must appear at
   logic [7:0]  mb [3][64];
   int          acc_c [3];
   int          rdy_c [3];
   int          end_c [3];
   int          rchg_c [3];
   logic [31:0] r_prev [3];
   logic [31:0] r_new [3];
   bit          efault [3];
   bit          chk_en = 1'b0;
   int          n_err = 0;
   int          n_chk = 0;

   task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d cycle %0d: got 0x%08h expected 0x%08h", nm, g, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] load_val(int g, logic [31:0] a, logic [1:0] s, bit e);
      logic [5:0]  i;
      logic [7:0]  b;
      logic [15:0] h;
      i = a[5:0];
      b = mb[g][i];
      h = {mb[g][i + 6'd1], mb[g][i]};
      case (s)
         2'b00:   return e ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   return e ? {16'd0, h} : {{16{h[15]}}, h};
         default: return {mb[g][i + 6'd3], mb[g][i + 6'd2], h};
      endcase
   endfunction

   task automatic store_val(int g, logic [31:0] a, logic [31:0] d, logic [1:0] s);
      logic [5:0] i;
      i = a[5:0];
      mb[g][i] = d[7:0];
      if (s != 2'b00) mb[g][i + 6'd1] = d[15:8];
      if (s == 2'b10) begin
         mb[g][i + 6'd2] = d[23:16];
         mb[g][i + 6'd3] = d[31:24];
      end
   endtask

   // Drives one request and returns in its RESP cycle; a call made during RESP is accepted a cycle later.
   task automatic txn(int g, bit rd, bit wr, logic [31:0] a, logic [31:0] d,
                      logic [1:0] s, bit e, bit hold);
      int k;
      bit f;
      logic [31:0] v;
      k = (cyc == rdy_c[g]) ? cyc + 1 : cyc;
      r_prev[g] = r_new[g];
      mr[g] = rd; mw[g] = wr; ad[g] = a; wd[g] = d; sz[g] = s; se[g] = e;
      f = (rd && wr) || (s == 2'b11) || (s == 2'b01 && a[0]) ||
          (s == 2'b10 && a[1:0] != 2'b00) || (a >= 32'h400);
      v = r_prev[g];
      if (!f && rd) v = load_val(g, a, s, e);
      if (!f && wr) store_val(g, a, d, s);
      r_new[g]  = v;
      efault[g] = f;
      acc_c[g]  = k;
      rdy_c[g]  = k + 1 + wt(g);
      end_c[g]  = rdy_c[g];
      rchg_c[g] = rdy_c[g];
      while (cyc < rdy_c[g]) tick();
      if (!hold) begin
         mr[g] = 1'b0;
         mw[g] = 1'b0;
      end
   endtask

   task automatic dchk(int g, string nm, logic [31:0] er, bit ef);
      chk({nm, " r_data"}, g, rdat[g], er);
      chk({nm, " ready"}, g, {31'd0, rdy[g]}, 32'd1);
      chk({nm, " fault"}, g, {31'd0, flt[g]}, {31'd0, ef});
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < 3; g++) begin
            bit er, eb;
            logic [31:0] erd;
            er  = (cyc == rdy_c[g]);
            eb  = (cyc > acc_c[g]) && (cyc <= end_c[g]);
            erd = (cyc >= rchg_c[g]) ? r_new[g] : r_prev[g];
            chk("ready", g, {31'd0, rdy[g]}, {31'd0, er});
            chk("busy", g, {31'd0, bsy[g]}, {31'd0, eb});
            chk("fault", g, {31'd0, flt[g]}, {31'd0, er && efault[g]});
            chk("r_data", g, rdat[g], erd);
         end
      end
   end

   initial begin
      int k, last, r, sel;
      bit hold;
      logic [1:0]  s;
      logic [31:0] a;
      rst = 3'b111;
      for (int g = 0; g < 3; g++) begin
         mr[g] = 1'b0; mw[g] = 1'b0; se[g] = 1'b0; ad[g] = 32'd0; wd[g] = 32'd0; sz[g] = 2'b00;
         acc_c[g] = -10; rdy_c[g] = -10; end_c[g] = -10; rchg_c[g] = -10;
         r_prev[g] = 32'd0; r_new[g] = 32'd0; efault[g] = 1'b0;
      end
      tick(); tick(); tick();
      for (int g = 0; g < 3; g++) begin
         chk("reset ready", g, {31'd0, rdy[g]}, 32'd0);
         chk("reset busy", g, {31'd0, bsy[g]}, 32'd0);
         chk("reset fault", g, {31'd0, flt[g]}, 32'd0);
         chk("reset r_data", g, rdat[g], 32'd0);
      end
      rst = 3'b000;
      chk_en = 1'b1;
      tick();

      for (int g = 0; g < 3; g++)
         for (int w = 0; w < 16; w++) begin
            txn(g, 1'b0, 1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0, 1'b0);
            tick();
         end

      // directed word/byte/half traffic on the WAIT=1 instance
      txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0);
      chk("sw latency", 0, cyc - acc_c[0], 32'd2);
      tick();
      txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 1'b0);
      chk("lw latency", 0, cyc - acc_c[0], 32'd2);
      dchk(0, "lw 0x10", 32'hDEADBEEF, 1'b0); tick();
      txn(0, 1'b1, 1'b0, 32'h13, 32'd0, 2'b00, 1'b0, 1'b0);
      dchk(0, "lb 0x13", 32'hFFFFFFDE, 1'b0); tick();
      txn(0, 1'b1, 1'b0, 32'h13, 32'd0, 2'b00, 1'b1, 1'b0);
      dchk(0, "lbu 0x13", 32'h000000DE, 1'b0); tick();
      txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'b01, 1'b0, 1'b0);
      dchk(0, "lh 0x10", 32'hFFFFBEEF, 1'b0); tick();
      txn(0, 1'b1, 1'b0, 32'h12, 32'd0, 2'b01, 1'b1, 1'b0);
      dchk(0, "lhu 0x12", 32'h0000DEAD, 1'b0); tick();
      txn(0, 1'b0, 1'b1, 32'h11, 32'h00000055, 2'b00, 1'b0, 1'b0); tick();
      txn(0, 1'b0, 1'b1, 32'h12, 32'h00001234, 2'b01, 1'b0, 1'b0); tick();
      txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 1'b0);
      dchk(0, "lw partial", 32'h123455EF, 1'b0); tick();
      txn(0, 1'b1, 1'b0, 32'h21, 32'd0, 2'b01, 1'b0, 1'b0);
      dchk(0, "lh misaligned", 32'h123455EF, 1'b1); tick();
      txn(0, 1'b0, 1'b1, 32'h22, 32'hFFFFFFFF, 2'b10, 1'b0, 1'b0);
      dchk(0, "sw misaligned", 32'h123455EF, 1'b1); tick();
      txn(0, 1'b1, 1'b0, 32'h20, 32'd0, 2'b11, 1'b0, 1'b0);
      dchk(0, "size 11", 32'h123455EF, 1'b1); tick();
      txn(0, 1'b1, 1'b0, 32'h400, 32'd0, 2'b10, 1'b0, 1'b0);
      dchk(0, "out of range", 32'h123455EF, 1'b1); tick();
      txn(0, 1'b1, 1'b1, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
      dchk(0, "read+write", 32'h123455EF, 1'b1); tick();
      txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 1'b0);
      dchk(0, "lw after faults", 32'h123455EF, 1'b0); tick();

      // reset in the second BUSY cycle of a WAIT=3 store
      txn(1, 1'b0, 1'b1, 32'h30, 32'h13572468, 2'b10, 1'b0, 1'b0); tick();
      k = cyc;
      r_prev[1] = r_new[1];
      mr[1] = 1'b0; mw[1] = 1'b1; ad[1] = 32'h30; wd[1] = 32'hAAAAAAAA; sz[1] = 2'b10;
      acc_c[1] = k; end_c[1] = k + 2; rdy_c[1] = -10; rchg_c[1] = k + 3; r_new[1] = 32'd0;
      tick(); tick();
      rst[1] = 1'b1; mw[1] = 1'b0;
      tick();
      rst[1] = 1'b0;
      chk("busy after reset", 1, {31'd0, bsy[1]}, 32'd0);
      tick();
      txn(1, 1'b1, 1'b0, 32'h30, 32'd0, 2'b10, 1'b0, 1'b0);
      dchk(1, "lw after abort", 32'h13572468, 1'b0); tick();

      // WAIT=0: held request responds every second cycle; a request raised in RESP waits for IDLE
      txn(2, 1'b1, 1'b0, 32'h04, 32'd0, 2'b10, 1'b0, 1'b1);
      last = cyc;
      for (int i = 0; i < 4; i++) begin
         txn(2, 1'b1, 1'b0, 32'h04, 32'd0, 2'b10, 1'b0, (i != 3));
         chk("held spacing", 2, cyc - last, 32'd2);
         last = cyc;
      end
      #2;
      txn(2, 1'b1, 1'b0, 32'h0C, 32'd0, 2'b10, 1'b0, 1'b0);
      chk("raised in RESP spacing", 2, cyc - last, 32'd2);
      tick();

      for (int g = 0; g < 3; g++) begin
         for (int n = 0; n < 100; n++) begin
            r   = $urandom_range(0, 9);
            sel = $urandom_range(0, 15);
            s   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (sel == 0)      a = 32'h400 + 32'($urandom_range(0, 255));
            else if (sel == 1) a = $urandom | 32'h0001_0000;
            else               a = 32'($urandom_range(0, 63));
            hold = ($urandom_range(0, 3) == 0);
            txn(g, (r <= 5), (r == 0 || r > 5), a, $urandom, s, 1'($urandom_range(0, 1)), hold);
            if (!hold)
               repeat ($urandom_range(0, 2)) tick();
         end
         mr[g] = 1'b0;
         mw[g] = 1'b0;
         tick();
      end

      tick(); tick(); tick();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder on the core's load/store port. Accepts one request at a time from the multi-cycle control unit: `Mem_read` or `Mem_write`, plus address, size and extension select. Stores into an internal word array with byte-lane enables. Returns loads as a registered, sign- or zero-extended 32-bit value, with a one-cycle `ready` pulse after a configurable number of wait states.

## Interface
- `ADDR_W`, default 10: byte-address width implemented; depth is 2^(ADDR_W-2) 32-bit words.
- `WAIT`, default 1: wait-state cycles between acceptance and response (0..15).

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Mem_read`  in  1  load request.
- `Mem_write`  in  1  store request.
- `addr`  in  32  byte address.
- `w_data`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `Size_s`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `SE_s`  in  1  load extension: 0 sign-extend, 1 zero-extend; ignored for stores and word loads.
- `r_data`  out  32  load result register (MDR).
- `ready`  out  1  one-cycle response pulse.
- `fault`  out  1  valid with `ready`; request rejected.
- `busy`  out  1  high in BUSY and RESP.

## Operation
- FSM states are IDLE, BUSY and RESP.
- **IDLE**
  - If `Mem_read | Mem_write`, latch `addr`, `w_data`, `Size_s`, `SE_s` and the request type.
  - Go to BUSY with wait counter = `WAIT`-1. If `WAIT`=0, go directly to RESP.
  - Otherwise stay in IDLE.
- **BUSY**
  - Decrement the counter. At 0, go to RESP.
  - Input changes are ignored.
- **RESP**
  - `ready`=1 for exactly one cycle, then return to IDLE.
- Fault is evaluated on latched values. A request faults if any of these holds:
  - `Mem_read` and `Mem_write` are both high;
  - `Size_s`=11;
  - a half access has addr[0]=1;
  - a word access has addr[1:0]≠0;
  - addr[31:ADDR_W]≠0.
- On fault:
  - `fault`=1 with `ready`;
  - memory is unchanged;
  - `r_data` holds its previous value.
- Store commit happens on the clock edge that enters RESP. Byte lanes written:
  - byte: lane addr[1:0], written with w_data[7:0];
  - half: lanes {addr[1],1} and {addr[1],0}, written with w_data[15:0];
  - word: all four lanes.
- Load: `r_data` is loaded on the edge entering RESP with the extracted lane data.
  - byte/half with `SE_s`=0 sign-extends from bit 7/15.
  - byte/half with `SE_s`=1 zero-extends.
  - word is passed through.
- A store does not change `r_data`.

## Timing
- Reset values: state IDLE, `r_data`=0, `ready`=0, `fault`=0, `busy`=0, counter 0. Memory array is not reset.
- A request sampled in IDLE at cycle t produces `ready` at cycle t+`WAIT`+1.
- The earliest next acceptance is cycle t+`WAIT`+2, in IDLE.
- Requests asserted during BUSY/RESP are ignored, not queued. The requester holds the request until it sees `ready`, then deasserts.
- A request still high in the IDLE cycle after RESP is accepted as a new request.
- Reset asserted in BUSY aborts the transfer. The pending store is not committed, and `ready` does not pulse.
- Reset in RESP forces IDLE on the next edge. A store committed on RESP entry stays committed.
- Load-after-store to the same word returns the new data, since commit precedes the next acceptance.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_B`=2'b00, `SZ_H`=2'b01, `SZ_W`=2'b10;
  - FSM state enum `mem_st_t` {IDLE, BUSY, RESP};
  - extension encodings `EXT_S`=0, `EXT_U`=1.
- One sub-module `mem_lane`, combinational:
  - store path: byte-enable and write-data replication from size/addr[1:0];
  - load path: lane extraction and extension from size/addr[1:0]/ext.
- The FSM, counter, latches and array stay in `data_mem_ctrl`.

## Test plan
- Word store/load, `WAIT`=1: store 0xDEADBEEF at 0x10, then load word at 0x10. Required: `r_data`=0xDEADBEEF; `ready` two cycles after each acceptance; `fault`=0.
- Byte sign/zero extension: with 0x10 holding 0xDEADBEEF:
  - lb 0x13 gives 0xFFFFFFDE;
  - lbu 0x13 gives 0x000000DE;
  - lh 0x10 gives 0xFFFFBEEF;
  - lhu 0x12 gives 0x0000DEAD.
- Partial store: sb 0x55 at 0x11, then sh 0x1234 at 0x12. A word load at 0x10 returns 0x123455EF.
- Faults:
  - half load at 0x21, word store at 0x22, `Size_s`=11, addr 0x400 (`ADDR_W`=10), and read+write together each give `ready`=`fault`=1;
  - memory and `r_data` are unchanged.
- Reset mid-operation: with `WAIT`=3, store 0xAAAAAAAA to 0x30 and assert `rst` in the second BUSY cycle. No `ready` pulse; `busy`=0 next cycle; a later load at 0x30 returns the old value.
- `WAIT`=0 back-to-back: a request held high gives `ready` every second cycle. A request raised during RESP is only accepted in the following IDLE cycle.
